// File: rtl/tmds_channel_decoder_if.sv
// rtl/tmds_channel_decoder_if.sv - bus bundle between deserializer, TMDS decoder and video sink
//
// Purpose: groups the deserialized TMDS word and the decoded channel outputs.
// Signals:
//   raw    [9:0] deserialized word, raw[0] earliest received bit
//   dout   [7:0] decoded video data
//   de           1 = dout valid video, 0 = ctrl valid
//   ctrl   [1:0] decoded control value {c1,c0}
//   locked       word alignment established
//   slip   [3:0] current bit offset, 0..9
// Modports: master = source/sink side, slave = decoder side.

interface tmds_channel_decoder_if;
   logic [9:0] raw;
   logic [7:0] dout;
   logic       de;
   logic [1:0] ctrl;
   logic       locked;
   logic [3:0] slip;

   modport master (
      output raw,
      input  dout, de, ctrl, locked, slip
   );

   modport slave (
      input  raw,
      output dout, de, ctrl, locked, slip
   );
endinterface

// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS channel word aligner, decoder and lock tracker
//
// Purpose: finds the 10-bit word boundary in an unaligned deserialized TMDS
// stream using control-token runs, decodes each aligned word to 8-bit video
// data or a 2-bit control value, and tracks link lock.
// Ports:
//   pixclk  pixel clock, all logic on its rising edge
//   resetn  asynchronous active-low reset
//   bus     tmds_channel_decoder_if.slave (raw in; dout/de/ctrl/locked/slip out)
// Parameters:
//   LOCK_RUN       consecutive tokens at one offset needed to lock
//   SEARCH_WINDOW  cycles without a completed run before the offset advances
//   UNLOCK_WINDOW  cycles without any token before lock is dropped

module tmds_channel_decoder #(
   parameter int LOCK_RUN      = 8,
   parameter int SEARCH_WINDOW = 1024,
   parameter int UNLOCK_WINDOW = 2048
) (
   input logic                   pixclk,
   input logic                   resetn,
   tmds_channel_decoder_if.slave bus
);

   localparam int RUN_W  = $clog2(LOCK_RUN + 1);
   localparam int SRCH_W = $clog2(SEARCH_WINDOW + 1);
   localparam int IDLE_W = $clog2(UNLOCK_WINDOW + 1);

   typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

   state_t            state, state_nxt;
   logic [9:0]        raw_prev, aq, aligned;
   logic [18:0]       window;
   logic [RUN_W-1:0]  run_cnt, run_nxt;
   logic [SRCH_W-1:0] search_cnt, search_nxt;
   logic [IDLE_W-1:0] idle_cnt, idle_nxt;
   logic [3:0]        slip, slip_nxt;
   logic              tok_hit;
   logic [1:0]        tok_val;
   logic [7:0]        q, d;
   logic [7:0]        dout;
   logic              de;
   logic [1:0]        ctrl;

   // Bit 19 of the 20-bit window can never be selected (max slip 9), so it is not carried.
   assign window = {bus.raw[8:0], raw_prev};

   always_comb begin
      aligned = window[9:0];
      for (int k = 1; k < 10; k++) begin
         if (slip == 4'(k)) aligned = window[k +: 10];
      end
   end

   always_comb begin
      tok_hit = 1'b1;
      tok_val = 2'b00;
      case (aq)
         10'b1101010100: tok_val = 2'b00;
         10'b0010101011: tok_val = 2'b01;
         10'b0101010100: tok_val = 2'b10;
         10'b1010101011: tok_val = 2'b11;
         default:        tok_hit = 1'b0;
      endcase
   end

   // aq[9] marks an inverted payload; aq[8] selects XOR (1) or XNOR (0) chaining.
   always_comb begin
      q    = aq[9] ? ~aq[7:0] : aq[7:0];
      d    = '0;
      d[0] = q[0];
      for (int i = 1; i < 8; i++) begin
         d[i] = aq[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      end
   end

   always_comb begin
      state_nxt  = state;
      run_nxt    = run_cnt;
      search_nxt = search_cnt;
      idle_nxt   = idle_cnt;
      slip_nxt   = slip;
      case (state)
         ST_SEARCH: begin
            if (!tok_hit)
               run_nxt = '0;
            else if (run_cnt != RUN_W'(LOCK_RUN))
               run_nxt = run_cnt + 1'b1;
            if (search_cnt != SRCH_W'(SEARCH_WINDOW))
               search_nxt = search_cnt + 1'b1;
            // A completed run wins over the offset advance in the same cycle.
            if (tok_hit && (run_cnt == RUN_W'(LOCK_RUN - 1))) begin
               state_nxt  = ST_LOCKED;
               search_nxt = '0;
            end else if (search_cnt == SRCH_W'(SEARCH_WINDOW - 1)) begin
               slip_nxt   = (slip == 4'd9) ? 4'd0 : slip + 4'd1;
               run_nxt    = '0;
               search_nxt = '0;
            end
         end
         ST_LOCKED: begin
            if (tok_hit) begin
               idle_nxt = '0;
            end else if (idle_cnt == IDLE_W'(UNLOCK_WINDOW - 1)) begin
               // Offset is kept so the search resumes where the link last was.
               state_nxt  = ST_SEARCH;
               run_nxt    = '0;
               search_nxt = '0;
               idle_nxt   = '0;
            end else begin
               idle_nxt = idle_cnt + 1'b1;
            end
         end
         default: state_nxt = ST_SEARCH;
      endcase
   end

   always_ff @(posedge pixclk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_SEARCH;
         raw_prev   <= '0;
         aq         <= '0;
         run_cnt    <= '0;
         search_cnt <= '0;
         idle_cnt   <= '0;
         slip       <= '0;
         dout       <= '0;
         de         <= 1'b0;
         ctrl       <= '0;
      end else begin
         state      <= state_nxt;
         raw_prev   <= bus.raw;
         aq         <= aligned;
         run_cnt    <= run_nxt;
         search_cnt <= search_nxt;
         idle_cnt   <= idle_nxt;
         slip       <= slip_nxt;
         // Gated by the lock state before this edge, so the word that
         // completes the run is still blanked and the next one is not.
         if (state != ST_LOCKED) begin
            dout <= '0;
            de   <= 1'b0;
            ctrl <= '0;
         end else if (tok_hit) begin
            dout <= '0;
            de   <= 1'b0;
            ctrl <= tok_val;
         end else begin
            dout <= d;
            de   <= 1'b1;
            ctrl <= '0;
         end
      end
   end

   assign bus.dout   = dout;
   assign bus.de     = de;
   assign bus.ctrl   = ctrl;
   assign bus.locked = (state == ST_LOCKED);
   assign bus.slip   = slip;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - self-checking bench for tmds_channel_decoder

module tb_tmds_channel_decoder;

   localparam int LR    = 8;
   localparam int SW    = 128;
   localparam int UW    = 256;
   localparam int BLANK = 16;
   localparam int LINE  = 80;
   localparam int BIG   = 1 << 30;

   logic pixclk = 1'b0;
   logic resetn = 1'b1;
   always #5 pixclk = ~pixclk;

   tmds_channel_decoder_if bus ();

   tmds_channel_decoder #(
      .LOCK_RUN(LR), .SEARCH_WINDOW(SW), .UNLOCK_WINDOW(UW)
   ) dut (
      .pixclk(pixclk),
      .resetn(resetn),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int t, disp, ncarry, vid_pos, lk_on, lk_off, last_tok, exp_slip;
   bit check_en;
   logic [31:0] carry;
   logic [1:0]  line_c;
   bit          sym_c  [4096];
   logic [7:0]  sym_v  [4096];
   bit          exp_lk [4096];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   function automatic logic [9:0] tok(input logic [1:0] c);
      case (c)
         2'b00:   return 10'b1101010100;
         2'b01:   return 10'b0010101011;
         2'b10:   return 10'b0101010100;
         default: return 10'b1010101011;
      endcase
   endfunction

   // DVI transmitter 8b/10b with running disparity.
   function automatic logic [9:0] tmds_enc(input logic [7:0] v);
      logic [8:0] qm;
      int n1d, n1, n0;
      n1d = $countones(v);
      qm[0] = v[0];
      if (n1d > 4 || (n1d == 4 && !v[0])) begin
         for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ v[i]);
         qm[8] = 1'b0;
      end else begin
         for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ v[i];
         qm[8] = 1'b1;
      end
      n1 = $countones(qm[7:0]);
      n0 = 8 - n1;
      if (disp == 0 || n1 == n0) begin
         disp += qm[8] ? (n1 - n0) : (n0 - n1);
         return {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      end else if ((disp > 0 && n1 > n0) || (disp < 0 && n0 > n1)) begin
         disp += 2 * int'(qm[8]) + n0 - n1;
         return {1'b1, qm[8], ~qm[7:0]};
      end else begin
         disp += -2 * int'(!qm[8]) + n1 - n0;
         return {1'b0, qm[8], qm[7:0]};
      end
   endfunction

   // Drive one raw word, clock, then check: output word t is symbol t-2,
   // blanked unless the link was locked after the previous edge.
   task automatic step_raw(input logic [9:0] w, input bit is_c, input logic [7:0] v);
      bit gate;
      bus.raw  = w;
      sym_c[t] = is_c;
      sym_v[t] = v;
      @(posedge pixclk);
      #1;
      exp_lk[t] = (t >= lk_on) && (t < lk_off);
      if (check_en) begin
         gate = (t >= 2) && exp_lk[t-1];
         chk("locked", 32'(bus.locked), 32'(exp_lk[t]));
         chk("slip", 32'(bus.slip), 32'(exp_slip));
         if (gate) begin
            chk("de", 32'(bus.de), 32'(!sym_c[t-2]));
            chk("ctrl", 32'(bus.ctrl), sym_c[t-2] ? 32'(sym_v[t-2][1:0]) : 32'd0);
            chk("dout", 32'(bus.dout), sym_c[t-2] ? 32'd0 : 32'(sym_v[t-2]));
         end else begin
            chk("gated", {21'd0, bus.de, bus.ctrl, bus.dout}, 32'd0);
         end
      end
      t++;
   endtask

   // Encode, then pass through an LSB-first serializer / deserializer
   // whose word boundary lags the transmitter by ncarry bits.
   task automatic step_sym(input bit is_c, input logic [7:0] v);
      logic [9:0]  w;
      logic [31:0] comb;
      if (is_c) begin
         w = tok(v[1:0]);
         disp = 0;
         last_tok = t;
      end else begin
         w = tmds_enc(v);
      end
      comb  = carry | (32'(w) << ncarry);
      carry = comb >> 10;
      step_raw(comb[9:0], is_c, v);
   endtask

   task automatic vid();
      if (vid_pos == 0) line_c = 2'($urandom_range(3));
      if (vid_pos < BLANK) step_sym(1'b1, {6'd0, line_c});
      else                 step_sym(1'b0, 8'($urandom));
      vid_pos = (vid_pos + 1) % LINE;
   endtask

   task automatic do_reset(input int off);
      resetn = 1'b0;
      repeat (2) @(posedge pixclk);
      @(negedge pixclk);
      resetn   = 1'b1;
      t        = 0;
      disp     = 0;
      ncarry   = off;
      carry    = $urandom & ((32'd1 << off) - 1);
      vid_pos  = 0;
      check_en = 1'b0;
      lk_on    = BIG;
      lk_off   = BIG;
      last_tok = -BIG;
   endtask

   task automatic wait_lock(input string tag, input int bound);
      while (t < bound) begin
         vid();
         if (bus.locked) break;
      end
      chk(tag, 32'(bus.locked), 32'd1);
      lk_on         = t - 1;
      lk_off        = BIG;
      exp_lk[t - 1] = 1'b1;
      check_en      = 1'b1;
   endtask

   initial begin
      bus.raw = '0;
      #12 resetn = 1'b0;
      #1;
      chk("reset_state", {17'd0, bus.locked, bus.slip, bus.de, bus.ctrl, bus.dout}, 32'd0);

      // Aligned link: exact lock edge and full round trip over 10 lines.
      do_reset(0);
      lk_on = LR + 1; exp_slip = 0; check_en = 1'b1;
      repeat (10 * LINE) vid();

      // Seven-bit offset: offset search, then round trip.
      do_reset(7);
      exp_slip = 7;
      wait_lock("lock_off7", 8 * SW + LINE);
      repeat (3 * LINE) vid();

      // Control decode and data corner values.
      for (int c = 0; c < 4; c++) repeat (16) step_sym(1'b1, 8'(c));
      foreach (sym_v[i]) if (i < 4) begin
         logic [7:0] corner [4];
         corner = '{8'h00, 8'hFF, 8'h55, 8'h10};
         repeat (4) step_sym(1'b0, corner[i]);
      end

      // Loss of lock: data only, lock drops UW cycles after the last token is counted.
      lk_off = last_tok + 2 + UW;
      repeat (UW + 8) step_sym(1'b0, 8'h3C);

      // Search resumes at the retained offset.
      check_en = 1'b0; lk_on = BIG; lk_off = BIG; vid_pos = 0;
      wait_lock("relock", t + 2 * LINE);
      repeat (LINE + 20) vid();

      // Asynchronous reset mid-lock with data flowing.
      #2 resetn = 1'b0;
      #1;
      chk("async_reset", {17'd0, bus.locked, bus.slip, bus.de, bus.ctrl, bus.dout}, 32'd0);
      do_reset(0);
      lk_on = LR + 1; exp_slip = 0; check_en = 1'b1;
      repeat (2 * LINE) vid();

      // Slip wrap on tokenless noise.
      do_reset(0);
      check_en = 1'b1;
      while (t < 10 * SW + 2) begin
         exp_slip = ((t + 1) / SW) % 10;
         step_raw(10'($urandom), 1'b0, 8'd0);
         if (t == 10 * SW) chk("run_cnt_wrap", 32'(dut.run_cnt), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
